// File: rtl/count_log_pkg.sv
// Shared types and widths for the counter change logger.
// A record is packed MSB-first as {ts, mask, count2, count1, count0}.
package count_log_pkg;

    localparam int CNT_W  = 8;
    localparam int NUM_CH = 3;
    localparam int TS_W   = 8;

    typedef enum logic [0:0] {
        UNPRIMED = 1'b0,
        RUN      = 1'b1
    } state_e;

    typedef struct packed {
        logic [TS_W-1:0]                ts;
        logic [NUM_CH-1:0]              mask;
        logic [NUM_CH-1:0][CNT_W-1:0]   cnt;
    } log_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, wrap-bit pointers and a registered occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      level_q;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o   = level_q;

    // Storage is data only; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/count_change_logger.sv
// Samples three counter channels, emits a timestamped record whenever any channel changed
// since the previous sample, and buffers records for a valid/ready sink; overflow is counted.
module count_change_logger #(
    parameter int CNT_W  = count_log_pkg::CNT_W,
    parameter int NUM_CH = count_log_pkg::NUM_CH,
    parameter int DEPTH  = 8,
    parameter int TS_W   = count_log_pkg::TS_W
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CH*CNT_W-1:0]              count_i,
    input  logic                                 sample_en,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_CH+NUM_CH*CNT_W+TS_W-1:0]  out_data,
    output logic [$clog2(DEPTH):0]               level,
    output logic [7:0]                           drop_cnt
);

    import count_log_pkg::*;

    localparam int REC_W = NUM_CH + NUM_CH*CNT_W + TS_W;

    state_e                    state_q;
    logic [NUM_CH*CNT_W-1:0]   prev_q;
    logic [TS_W-1:0]           ts_q;
    logic [7:0]                drop_q;
    logic [7:0]                drop_d;

    logic [NUM_CH-1:0]         mask;
    log_rec_t                  rec;
    logic                      gen_rec;
    logic                      pop;
    logic                      accept;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [REC_W-1:0]          head;

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mask[i] = (count_i[i*CNT_W +: CNT_W] != prev_q[i*CNT_W +: CNT_W]);
        end
    end

    always_comb begin
        rec      = '0;
        rec.ts   = ts_q;
        rec.mask = mask;
        rec.cnt  = count_i;
    end

    assign gen_rec = sample_en && (state_q == RUN) && (|mask);
    assign pop     = out_valid && out_ready;
    assign accept  = gen_rec && (!fifo_full || pop);

    always_comb begin
        drop_d = drop_q;
        if (gen_rec && !accept && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= UNPRIMED;
            prev_q  <= '0;
            ts_q    <= '0;
            drop_q  <= '0;
        end else begin
            ts_q   <= ts_q + TS_W'(1);
            drop_q <= drop_d;
            case (state_q)
                UNPRIMED: begin
                    if (sample_en) begin
                        prev_q  <= count_i;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (sample_en) begin
                        prev_q <= count_i;
                    end
                end
                default: state_q <= UNPRIMED;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push_i    (gen_rec),
        .wr_data_i (rec),
        .pop_i     (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (level)
    );

    // Storage is not reset, so the head is masked to keep out_data at zero when empty.
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head : '0;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_count_change_logger.sv
// Directed bench for count_change_logger: stimulus queues hand-computed records,
// a negedge monitor pops and compares each accepted record and checks head stability.
module tb_count_change_logger;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] count_i;
    logic        sample_en;
    logic        out_valid;
    logic        out_ready;
    logic [34:0] out_data;
    logic [3:0]  level;
    logic [7:0]  drop_cnt;

    logic [34:0] exp_q [$];
    logic [7:0]  tb_ts;
    logic [34:0] held;
    bit          holding;
    int          vectors;
    int          miscompares;

    always #5 clk = ~clk;

    count_change_logger dut (
        .clk       (clk),
        .reset     (reset),
        .count_i   (count_i),
        .sample_en (sample_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .drop_cnt  (drop_cnt)
    );

    always @(posedge clk or negedge reset) begin
        if (!reset) tb_ts <= 8'd0;
        else        tb_ts <= tb_ts + 8'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input logic [23:0] c, input logic [2:0] m, input bit kept);
        count_i   = c;
        sample_en = 1'b1;
        if (m != 3'b000 && kept) exp_q.push_back({tb_ts, m, c});
        tick();
        sample_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && !out_ready) begin
            if (holding) check("hold_stable", out_data, held);
            held    = out_data;
            holding = 1'b1;
        end else begin
            holding = 1'b0;
        end
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_record: got %0h, expected none", out_data);
            end else begin
                check("record", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        vectors   = 0;
        miscompares = 0;
        holding   = 1'b0;
        reset     = 1'b0;
        count_i   = 24'd0;
        sample_en = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_data",  out_data,  0);
        check("rst_level", level,     0);
        check("rst_drop",  drop_cnt,  0);
        tick();
        tick();
        reset = 1'b1;

        samp({8'd3, 8'd2, 8'd1}, 3'b000, 0);
        check("prime_level", level, 0);
        check("prime_valid", out_valid, 0);

        for (int k = 0; k < 64 && tb_ts != 8'h10; k++) tick();
        samp({8'd3, 8'd5, 8'd1}, 3'b010, 1);
        check("first_valid", out_valid, 1);
        check("first_data",  out_data, {8'h10, 3'b010, 8'd3, 8'd5, 8'd1});
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("drain1_level", level, 0);

        for (int k = 0; k < 10; k++) samp({8'd3, 8'd5, 8'(10 + k)}, 3'b001, k < 8);
        check("full_level", level, 8);
        check("full_drop",  drop_cnt, 2);
        check("full_head",  out_data[23:0], {8'd3, 8'd5, 8'd10});

        out_ready = 1'b1;
        samp({8'd3, 8'd5, 8'd20}, 3'b001, 1);
        out_ready = 1'b0;
        check("pp_level", level, 8);
        check("pp_drop",  drop_cnt, 2);
        check("pp_head",  out_data[23:0], {8'd3, 8'd5, 8'd11});

        out_ready = 1'b1;
        repeat (10) tick();
        check("drain2_level", level, 0);
        check("drain2_valid", out_valid, 0);

        samp({8'd3, 8'd5, 8'd255}, 3'b001, 1);
        samp({8'd4, 8'd6, 8'd0},   3'b111, 1);
        check("wrap_data", out_data[26:0], {3'b111, 8'd4, 8'd6, 8'd0});
        repeat (3) tick();
        out_ready = 1'b0;
        check("wrap_level", level, 0);

        for (int k = 0; k < 9; k++) samp({8'd4, 8'd6, 8'(30 + k)}, 3'b001, k < 8);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        check("pre_rst_level", level, 5);
        check("pre_rst_drop",  drop_cnt, 3);

        #3;
        reset = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_level", level, 0);
        check("arst_drop",  drop_cnt, 0);
        check("arst_data",  out_data, 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;

        samp({8'd9, 8'd9, 8'd9}, 3'b000, 0);
        check("reprime_level", level, 0);
        check("reprime_valid", out_valid, 0);
        samp({8'd9, 8'd9, 8'd10}, 3'b001, 1);
        check("post_valid", out_valid, 1);
        check("post_data",  out_data[26:0], {3'b001, 8'd9, 8'd9, 8'd10});
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        tick();
        check("queue_empty", exp_q.size(), 0);
        check("final_level", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
